clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Measures an incoming slow periodic signal against the system clock, e.g. a divided clock or tick line produced elsewhere in the design.
- Reports period and high time in clk cycles, plus a per-period valid pulse, a lock indication and a loss-of-signal timeout.
- Used as the monitor end of generated clock/tick lines and for bench self-checks of dividers.

Parameters:
- WIDTH, 32, width of the period, high-time and internal counters.
- TIMEOUT_CYCLES, 2_000_000, clk cycles without a detected rising edge before declaring loss of signal (2..2^WIDTH-1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- sig_in  input  1  measured signal; asynchronous to clk.
- enable  input  1  measurement enable; level-sensitive.
- period  output  WIDTH  last complete period, in clk cycles.
- high_time  output  WIDTH  high time of that same period, in clk cycles.
- valid  output  1  one-cycle pulse when period/high_time update.
- locked  output  1  last two captured periods are exactly equal.
- timeout  output  1  no rising edge for TIMEOUT_CYCLES while measuring; sticky.

Behaviour:
- Reset (async): sync flops s1, s2, s3 = 0; state = IDLE; cnt = 0; hcap = 0; prev_period = 0. All outputs = 0.
- Input path: 2-FF synchronizer s1 -> s2, then edge register s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - rise is seen 2 clk edges after sig_in is first sampled high; the registered outputs update on the 3rd edge.
- States:
  - IDLE: cnt held at 0. Moves to WAIT_FIRST when enable = 1.
  - WAIT_FIRST: cnt held at 0. On rise: cnt <= 0 and move to MEASURE. No valid pulse here, because the partial period is discarded.
  - MEASURE: cnt <= cnt + 1 each cycle, except as below.
    - On fall: hcap <= cnt + 1.
    - On rise: period <= cnt + 1; high_time <= hcap; prev_period <= cnt + 1; valid <= 1; timeout <= 0; locked <= (cnt + 1 == prev_period); cnt <= 0.
    - When cnt == TIMEOUT_CYCLES-1 with no rise in the same cycle: timeout <= 1; locked <= 0; prev_period <= 0; cnt <= 0; move to WAIT_FIRST.
- enable = 0 in any state: go to IDLE next cycle. cnt, hcap and prev_period are cleared. locked and timeout are cleared. period and high_time hold their values.
- valid is high for exactly one cycle per captured period. It is never asserted from WAIT_FIRST or IDLE.
- Period semantics: a signal whose rising edges are D clk cycles apart gives period = D. A high phase of H cycles gives high_time = H.
- Simultaneous rise and timeout terminal count: rise wins and the period is captured normally.
- fall and rise cannot coincide, because they come from the same synchronized sample.
- A glitch shorter than one clk period may be missed. This is acceptable.
- Reset asserted mid-measurement immediately returns the block to its reset state. The first valid after release needs two rising edges.

Test Plan:
- sig_in toggles every 5 clk cycles (D = 10), enable = 1: the first valid comes on the 2nd detected rise with period = 10 and high_time = 5. valid then pulses every 10 cycles. locked = 1 from the 2nd valid onward.
- Duty test, high 3 / low 7 cycles: period = 10, high_time = 3 on every valid.
- Period change from D = 10 to D = 14 mid-stream: the first 14 capture drops locked to 0. The second 14 capture sets locked = 1. There is no spurious valid.
- TIMEOUT_CYCLES = 64, sig_in held low after a rise: timeout = 1 exactly 64 cycles after that rise detection, and locked = 0. On restart, the first rise gives no valid. The second rise gives valid and timeout = 0.
- Drop enable for 3 cycles mid-stream: locked = 0 and timeout = 0, while period and high_time hold. After re-enable, the first valid comes on the 2nd rise.
- Assert reset asynchronously, between clk edges, mid-period: all outputs are 0 immediately. After release, the full D = 10 sequence is reproduced.

Source files
------------

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the period and high time of a slow signal
// that is asynchronous to clk, counted in clk cycles. It also produces a
// per-period valid pulse, a lock flag (two equal periods in a row) and a
// sticky loss-of-signal timeout.
module clock_period_meter #(
  parameter int              WIDTH          = 32,
  parameter longint unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  // Last count value of a measurement window. Reaching it without a rise
  // means loss of signal.
  localparam logic [WIDTH-1:0] TC_LAST = WIDTH'(TIMEOUT_CYCLES - 64'd1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  state_t state, state_n;

  logic s1, s2, s3;
  logic rise, fall;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] hcap;
  logic [WIDTH-1:0] prev_period;

  // Strobes decoded by the FSM and consumed by the datapath.
  logic cap;      // rise in MEASURE: capture a full period
  logic tc_hit;   // terminal count in MEASURE with no rise

  // Two-flop synchronizer followed by an edge-detect register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Both edges come from the same synchronized sample pair, so they can
  // never be active together.
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign cnt_inc = cnt + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and strobe decode. A low enable overrides everything.
  // A rise on the terminal-count cycle takes priority over the timeout.
  always_comb begin
    state_n = state;
    cap     = 1'b0;
    tc_hit  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:       state_n = WAIT_FIRST;
        WAIT_FIRST: if (rise) state_n = MEASURE;
        MEASURE: begin
          if (rise) begin
            cap = 1'b1;
          end else if (cnt == TC_LAST) begin
            tc_hit  = 1'b1;
            state_n = WAIT_FIRST;
          end
        end
        default:    state_n = IDLE;
      endcase
    end
  end

  // Datapath: cycle counter, high-time capture, result registers and flags.
  // The first rise after WAIT_FIRST only arms the counter, because the
  // partial period before it is meaningless. period and high_time keep
  // their values across an enable drop, so software can still read the
  // last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      hcap        <= '0;
      prev_period <= '0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      valid <= cap;
      if (!enable) begin
        cnt         <= '0;
        hcap        <= '0;
        prev_period <= '0;
        locked      <= 1'b0;
        timeout     <= 1'b0;
      end else if (state != MEASURE) begin
        cnt <= '0;
      end else if (cap) begin
        period      <= cnt_inc;
        high_time   <= hcap;
        prev_period <= cnt_inc;
        locked      <= (cnt_inc == prev_period);
        timeout     <= 1'b0;
        cnt         <= '0;
      end else if (tc_hit) begin
        timeout     <= 1'b1;
        locked      <= 1'b0;
        prev_period <= '0;
        cnt         <= '0;
      end else begin
        cnt <= cnt_inc;
        if (fall) hcap <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter. A small pattern generator drives
// sig_in with a high/low cycle count. Valid spacing, captured values, lock
// and timeout are compared against hand-computed numbers.
module tb_clock_period_meter;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        sig_in = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        locked;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  // sig_in pattern: high for hi cycles, then low for lo cycles.
  int hi     = 5;
  int lo     = 5;
  int pos    = 9;
  bit gen_on = 1'b0;
  int n;

  always #5 clk = ~clk;

  clock_period_meter #(
    .WIDTH         (32),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .enable   (enable),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .locked   (locked),
    .timeout  (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clk, sample point is 1 ns after the edge, then step the pattern.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gen_on) begin
      pos    = (pos + 1 >= hi + lo) ? 0 : pos + 1;
      sig_in = (pos < hi);
    end
  endtask

  // Tick until valid is seen (bounded). n is the number of ticks taken.
  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!valid && cnt < max);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high"}, high_time, 0);
    check({tag, "_valid"}, {31'd0, valid}, 0);
    check({tag, "_locked"}, {31'd0, locked}, 0);
    check({tag, "_timeout"}, {31'd0, timeout}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check_zero("rst");

    // D = 10, 5/5 duty
    reset  = 1'b0;
    enable = 1'b1;
    gen_on = 1'b1;
    wait_valid(40, n);
    check("t1_first_gap", n, 14);
    check("t1_period", period, 10);
    check("t1_high", high_time, 5);
    check("t1_locked0", {31'd0, locked}, 0);
    check("t1_timeout", {31'd0, timeout}, 0);
    tick();
    check("t1_pulse_width", {31'd0, valid}, 0);
    wait_valid(30, n);
    check("t1_gap2", n, 9);
    check("t1_period2", period, 10);
    check("t1_locked1", {31'd0, locked}, 1);
    wait_valid(30, n);
    check("t1_gap3", n, 10);
    check("t1_high3", high_time, 5);
    check("t1_locked2", {31'd0, locked}, 1);

    // Duty 3/7
    hi = 3;
    lo = 7;
    wait_valid(30, n);
    check("t2_gap_transition", n, 10);
    wait_valid(30, n);
    check("t2_gap", n, 10);
    check("t2_period", period, 10);
    check("t2_high", high_time, 3);
    check("t2_locked", {31'd0, locked}, 1);
    wait_valid(30, n);
    check("t2_high2", high_time, 3);

    // Period change 10 -> 14
    lo = 11;
    wait_valid(40, n);
    check("t3_gap", n, 14);
    check("t3_period", period, 14);
    check("t3_locked0", {31'd0, locked}, 0);
    wait_valid(40, n);
    check("t3_gap2", n, 14);
    check("t3_period2", period, 14);
    check("t3_locked1", {31'd0, locked}, 1);
    check("t3_high", high_time, 3);

    // Loss of signal, TIMEOUT_CYCLES = 64
    gen_on = 1'b0;
    sig_in = 1'b0;
    repeat (63) tick();
    check("t4_timeout_early", {31'd0, timeout}, 0);
    tick();
    check("t4_timeout", {31'd0, timeout}, 1);
    check("t4_locked", {31'd0, locked}, 0);
    check("t4_valid", {31'd0, valid}, 0);
    hi     = 5;
    lo     = 5;
    pos    = 9;
    gen_on = 1'b1;
    repeat (5) tick();
    check("t4_first_rise_valid", {31'd0, valid}, 0);
    check("t4_timeout_sticky", {31'd0, timeout}, 1);
    wait_valid(40, n);
    check("t4_restart_gap", n, 9);
    check("t4_restart_period", period, 10);
    check("t4_restart_high", high_time, 5);
    check("t4_restart_timeout", {31'd0, timeout}, 0);
    check("t4_restart_locked", {31'd0, locked}, 0);
    wait_valid(30, n);
    check("t4_relock", {31'd0, locked}, 1);

    // Enable dropped for 3 cycles
    enable = 1'b0;
    tick();
    check("t5_locked", {31'd0, locked}, 0);
    check("t5_timeout", {31'd0, timeout}, 0);
    check("t5_valid", {31'd0, valid}, 0);
    tick();
    tick();
    check("t5_period_hold", period, 10);
    check("t5_high_hold", high_time, 5);
    enable = 1'b1;
    wait_valid(40, n);
    check("t5_reenable_gap", n, 17);
    check("t5_period", period, 10);
    check("t5_locked0", {31'd0, locked}, 0);
    wait_valid(30, n);
    check("t5_locked1", {31'd0, locked}, 1);

    // Asynchronous reset mid-period
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check_zero("t6_async");
    gen_on = 1'b0;
    sig_in = 1'b0;
    pos    = 9;
    tick();
    tick();
    reset  = 1'b0;
    gen_on = 1'b1;
    wait_valid(40, n);
    check("t6_first_gap", n, 14);
    check("t6_period", period, 10);
    check("t6_high", high_time, 5);
    check("t6_locked0", {31'd0, locked}, 0);
    wait_valid(30, n);
    check("t6_gap2", n, 10);
    check("t6_locked1", {31'd0, locked}, 1);
    tick();
    check("t6_pulse_width", {31'd0, valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
